// File: rtl/n64_input_recorder.sv
// Purpose: records N64 controller frames into a FIFO and streams them to the host as 8N1 UART bytes (MSB byte first).
// Latency: strobe at edge N is written at N, popped at N+1, and tx_uart goes low (start bit) from edge N+2.
// Backpressure: none upstream; a frame strobed while the FIFO is full (and not popping) is dropped and sets sticky overflow.
// Optional: define RECORDER_SYNC_BYTE_EN to prefix every frame with sync byte 0xA5 (5 bytes per frame).

// Generic circular FIFO; pointers carry one extra wrap bit to tell full from empty.
// Latency: a written word is visible on rd_dat the cycle after its write edge.
// Backpressure: caller must not write while full unless it reads in the same cycle.
module fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_vld,
    input  logic [W-1:0]            wr_dat,
    input  logic                    rd_rdy,
    output logic [W-1:0]            rd_dat,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    assign count  = wr_ptr - rd_ptr;
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_dat = mem[rd_ptr[AW-1:0]];

    // Pointer advance; a write into a full FIFO lands in the slot being read this cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_vld) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_rdy) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        if (wr_vld) mem[wr_ptr[AW-1:0]] <= wr_dat;
    end
endmodule

module n64_input_recorder #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 1000000,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        frame_valid,
    input  logic [31:0] frame_data,
    input  logic        clear_overflow,
    output logic        tx_uart,
    output logic        busy,
    output logic        overflow,
    output logic [15:0] frame_count
);
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE  = 1;
`ifdef RECORDER_SYNC_BYTE_EN
    localparam logic [2:0] LAST_BYTE = 3'd4;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
`else
    localparam logic [2:0] LAST_BYTE = 3'd3;
`endif

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [2:0]    byte_idx;
    logic [7:0]    cur_byte;
    logic [31:0]   shreg;
    logic          cnt_done;
    logic          tx_nxt;
    logic          busy_nxt;
    logic          fifo_wr;
    logic          fifo_rd;
    logic          fifo_full;
    logic          fifo_empty;
    logic [31:0]   fifo_rd_dat;
    logic [AW:0]   fifo_count;
    logic [AW:0]   occ_nxt;
    logic          drop;

    fifo #(.W(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (sys_clk),
        .rst_n  (rst_n),
        .wr_vld (fifo_wr),
        .wr_dat (frame_data),
        .rd_rdy (fifo_rd),
        .rd_dat (fifo_rd_dat),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign fifo_wr  = frame_valid & enable & (~fifo_full | fifo_rd);
    assign drop     = frame_valid & enable & fifo_full & ~fifo_rd;
    assign cnt_done = (clk_cnt == CNT_LAST);
    assign occ_nxt  = fifo_count + {{AW{1'b0}}, fifo_wr} - {{AW{1'b0}}, fifo_rd};
    assign busy_nxt = (occ_nxt != '0) || (state_nxt != IDLE);

    // Next-state, FIFO pop and line level for the current bit period.
    always_comb begin
        state_nxt = state;
        fifo_rd   = 1'b0;
        tx_nxt    = 1'b1;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_rd   = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                tx_nxt = 1'b0;
                if (cnt_done) state_nxt = DATA;
            end
            DATA: begin
                tx_nxt = cur_byte[bit_idx];
                if (cnt_done && bit_idx == 3'd7) state_nxt = STOP;
            end
            STOP: begin
                if (cnt_done) state_nxt = (byte_idx == LAST_BYTE) ? IDLE : START;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Serializer datapath; tx_uart is registered so it trails the state by one cycle.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            clk_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            cur_byte <= '0;
            shreg    <= '0;
            tx_uart  <= 1'b1;
            busy     <= 1'b0;
        end else begin
            tx_uart <= tx_nxt;
            busy    <= busy_nxt;
            if (state == IDLE || cnt_done) clk_cnt <= '0;
            else                           clk_cnt <= clk_cnt + CNT_ONE;
            if (fifo_rd) begin
                byte_idx <= '0;
                bit_idx  <= '0;
`ifdef RECORDER_SYNC_BYTE_EN
                cur_byte <= SYNC_BYTE;
                shreg    <= fifo_rd_dat;
`else
                cur_byte <= fifo_rd_dat[31:24];
                shreg    <= {fifo_rd_dat[23:0], 8'h00};
`endif
            end
            if (state == DATA && cnt_done) bit_idx <= bit_idx + 3'd1;
            if (state == STOP && cnt_done && state_nxt == START) begin
                byte_idx <= byte_idx + 3'd1;
                cur_byte <= shreg[31:24];
                shreg    <= {shreg[23:0], 8'h00};
            end
        end
    end

    // Accepted-frame counter and sticky overflow; a drop beats a same-cycle clear.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            frame_count <= '0;
            overflow    <= 1'b0;
        end else begin
            if (fifo_wr)             frame_count <= frame_count + 16'd1;
            if (drop)                overflow    <= 1'b1;
            else if (clear_overflow) overflow    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_n64_input_recorder.sv
module tb_n64_input_recorder;
    localparam int CLK_HZ     = 10;
    localparam int BAUD       = 1;
    localparam int FIFO_DEPTH = 4;
`ifdef RECORDER_SYNC_BYTE_EN
    localparam int NBYTES = 5;
`else
    localparam int NBYTES = 4;
`endif
    localparam int FRAME_CYC = 100 * NBYTES;

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        frame_valid = 1'b0;
    logic [31:0] frame_data = '0;
    logic        clear_overflow = 1'b0;
    logic        tx_uart;
    logic        busy;
    logic        overflow;
    logic [15:0] frame_count;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    n64_input_recorder #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .sys_clk        (sys_clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .frame_valid    (frame_valid),
        .frame_data     (frame_data),
        .clear_overflow (clear_overflow),
        .tx_uart        (tx_uart),
        .busy           (busy),
        .overflow       (overflow),
        .frame_count    (frame_count)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Queue the bytes the host should see for one accepted frame.
    task automatic expect_frame(input logic [31:0] d);
`ifdef RECORDER_SYNC_BYTE_EN
        exp_q.push_back(8'hA5);
`endif
        exp_q.push_back(d[31:24]);
        exp_q.push_back(d[23:16]);
        exp_q.push_back(d[15:8]);
        exp_q.push_back(d[7:0]);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic strobe(input logic [31:0] d);
        tick();
        frame_valid = 1'b1;
        frame_data  = d;
        tick();
        frame_valid = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        check("idle_within_budget", busy, 0);
        repeat (10) @(negedge sys_clk);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic count_tx_low(input int cycles, output int lows);
        lows = 0;
        repeat (cycles) begin
            @(negedge sys_clk);
            if (tx_uart !== 1'b1) lows++;
        end
    endtask

    // UART monitor: decodes 8N1 at mid-bit and compares each byte with the scoreboard.
    initial begin : monitor
        int          tk;
        bit          active;
        logic [7:0]  sh;
        active = 0;
        tk = 0;
        sh = '0;
        forever begin
            @(negedge sys_clk);
            if (!rst_n) begin
                active = 0;
            end else if (!active) begin
                if (tx_uart === 1'b0) begin
                    active = 1;
                    tk = 0;
                end
            end else begin
                tk++;
                if (tk == 4) begin
                    check("start_bit", tx_uart, 0);
                end else if (tk >= 14 && tk <= 84 && (tk - 14) % 10 == 0) begin
                    sh[(tk - 14) / 10] = tx_uart;
                end else if (tk == 94) begin
                    check("stop_bit", tx_uart, 1);
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_byte: got 0x%0h, expected no byte", sh);
                    end else begin
                        check("rx_byte", sh, exp_q.pop_front());
                    end
                    active = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin : stim
        int cnt;
        int lows;

        // Reset state
        repeat (2) tick();
        rst_n = 1'b1;
        @(negedge sys_clk);
        check("rst_tx", tx_uart, 1);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_frame_count", frame_count, 0);

        // Single frame: latency, length, busy profile
        enable = 1'b1;
        expect_frame(32'h12345678);
        strobe(32'h12345678);
        @(negedge sys_clk);
        check("t1_busy_after_write", busy, 1);
        check("t1_tx_idle_n", tx_uart, 1);
        @(negedge sys_clk);
        check("t1_tx_idle_n1", tx_uart, 1);
        @(negedge sys_clk);
        check("t1_tx_start_n2", tx_uart, 0);
        cnt = 0;
        while (busy === 1'b1 && cnt < 2000) begin
            @(negedge sys_clk);
            cnt++;
        end
        check("t1_busy_cycles", cnt, FRAME_CYC - 1);
        wait_idle(100);
        check("t1_frame_count", frame_count, 1);

        // Overflow: 6 back-to-back strobes into a depth-4 FIFO
        do_reset();
        enable = 1'b1;
        for (int k = 1; k <= 5; k++) expect_frame(k);
        for (int k = 1; k <= 6; k++) begin
            frame_valid = 1'b1;
            frame_data  = k;
            tick();
        end
        frame_valid = 1'b0;
        @(negedge sys_clk);
        check("t2_overflow_set", overflow, 1);
        wait_idle(5 * FRAME_CYC + 200);
        check("t2_frame_count", frame_count, 5);
        check("t2_overflow_sticky", overflow, 1);
        tick();
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        @(negedge sys_clk);
        check("t2_overflow_cleared", overflow, 0);

        // Enable gating
        do_reset();
        enable = 1'b0;
        repeat (3) strobe(32'h55AA55AA);
        count_tx_low(30, lows);
        check("t3_tx_quiet", lows, 0);
        check("t3_frame_count0", frame_count, 0);
        check("t3_busy0", busy, 0);
        check("t3_overflow0", overflow, 0);
        enable = 1'b1;
        expect_frame(32'hDEADBEEF);
        strobe(32'hDEADBEEF);
        wait_idle(FRAME_CYC + 100);
        check("t3_frame_count1", frame_count, 1);

        // Full FIFO with a push on the exact pop cycle
        do_reset();
        enable = 1'b1;
        for (int k = 0; k < 6; k++) expect_frame(32'hA0B0C000 + k);
        tick();
        for (int k = 0; k < 5; k++) begin
            frame_valid = 1'b1;
            frame_data  = 32'hA0B0C000 + k;
            tick();
        end
        frame_valid = 1'b0;
        repeat (FRAME_CYC - 3) tick();
        frame_valid = 1'b1;
        frame_data  = 32'hA0B0C005;
        tick();
        frame_valid = 1'b0;
        @(negedge sys_clk);
        check("t4_no_overflow", overflow, 0);
        check("t4_frame_count", frame_count, 6);
        wait_idle(6 * FRAME_CYC + 200);

        // Reset in the middle of a data bit of the third byte
        do_reset();
        enable = 1'b1;
        expect_frame(32'h11223344);
        strobe(32'h11223344);
        repeat (239) tick();
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge sys_clk);
        check("t5_tx_low_before_rst", tx_uart, 0);
        tick();
        rst_n = 1'b1;
        @(negedge sys_clk);
        check("t5_tx_after_rst", tx_uart, 1);
        check("t5_busy_after_rst", busy, 0);
        check("t5_count_after_rst", frame_count, 0);
        count_tx_low(20, lows);
        check("t5_fifo_empty_quiet", lows, 0);
        expect_frame(32'hCAFEF00D);
        strobe(32'hCAFEF00D);
        wait_idle(FRAME_CYC + 100);
        check("t5_frame_count1", frame_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
